// File: rtl/ram_port_master.sv
// ram_port_master: clocked initiator for one port of an async cs/we/oe RAM.
// Turns single-beat valid/ready requests into setup/strobe/hold sequences.
module ram_port_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_data_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    // Phase counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] L_SETUP  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] L_STROBE = 4'(STROBE_CYC - 1);
    localparam logic [3:0] L_HOLD   = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_active;
    logic                  w_last_strobe;

    logic                  r_write;
    logic                  w_write_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_cap;

    logic                  r_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic [DATA_WIDTH-1:0] r_wdata_out;
    logic                  r_data_oe;

    // Next-state and phase-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = L_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = L_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    if (HOLD_CYC == 0) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = L_HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Latched request fields and next-cycle strobe qualifiers.
    always_comb begin
        w_write_nxt   = w_accept ? req_write : r_write;
        w_addr_nxt    = w_accept ? req_addr : r_addr;
        w_wdata_nxt   = w_accept ? req_wdata : r_wdata;
        w_active      = (w_state_nxt == S_SETUP) ||
                        (w_state_nxt == S_STROBE) ||
                        (w_state_nxt == S_HOLD);
        w_last_strobe = (r_state == S_STROBE) && (r_cnt == 4'd0);
    end

    // State register, request latches and flop-driven RAM/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cap       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_wdata_out <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_cs        <= w_active;
            r_we        <= (w_state_nxt == S_STROBE) && w_write_nxt;
            r_oe        <= (w_state_nxt == S_STROBE) && !w_write_nxt;
            r_data_oe   <= w_active && w_write_nxt;
            r_wdata_out <= (w_active && w_write_nxt) ? w_wdata_nxt : '0;
            if (w_last_strobe && !r_write) begin
                r_cap <= ram_rdata;
            end
            r_rsp_valid <= (w_state_nxt == S_DONE);
            if ((w_state_nxt == S_DONE) && !r_write) begin
                r_rsp_rdata <= w_last_strobe ? ram_rdata : r_cap;
            end else begin
                r_rsp_rdata <= '0;
            end
        end
    end

    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign ram_addr    = r_addr;
    assign ram_cs      = r_cs;
    assign ram_we      = r_we;
    assign ram_oe      = r_oe;
    assign ram_wdata   = r_wdata_out;
    assign ram_data_oe = r_data_oe;

    // Bus-protocol invariants of the RAM port.
    a_we_oe_excl: assert property (@(posedge clk) !(ram_we && ram_oe));
    a_strobe_cs: assert property (@(posedge clk) (ram_we || ram_oe) |-> ram_cs);
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (ram_cs && $past(ram_cs)) |-> (ram_addr == $past(ram_addr)));
    a_doe_read: assert property (@(posedge clk) ram_oe |-> !ram_data_oe);

endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: directed checks of strobe timing, read capture,
// back-to-back requests, short-phase configuration and mid-write reset.
module tb_ram_port_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [5:0]  ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic [15:0] ram_wdata;
    logic        ram_data_oe;
    logic [15:0] ram_rdata;

    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic        b_req_write = 1'b0;
    logic [5:0]  b_req_addr  = '0;
    logic [15:0] b_req_wdata = '0;
    logic        b_rsp_valid;
    logic [15:0] b_rsp_rdata;
    logic [5:0]  b_ram_addr;
    logic        b_ram_cs;
    logic        b_ram_we;
    logic        b_ram_oe;
    logic [15:0] b_ram_wdata;
    logic        b_ram_data_oe;
    logic [15:0] b_ram_rdata;

    logic [15:0] mem [64];
    logic        f_en  = 1'b0;
    logic [15:0] f_val = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] tr_cs, tr_we, tr_oe, tr_doe, tr_rv, tr_rdy;
    logic [15:0] tr_wd [16];
    logic [15:0] rsp_d;
    int          inv_bad = 0;
    int          stray   = 0;

    always #5 clk = ~clk;

    ram_port_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .ram_data_oe(ram_data_oe),
        .ram_rdata(ram_rdata)
    );

    ram_port_master #(
        .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(0)
    ) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .ram_addr(b_ram_addr), .ram_cs(b_ram_cs),
        .ram_we(b_ram_we), .ram_oe(b_ram_oe),
        .ram_wdata(b_ram_wdata), .ram_data_oe(b_ram_data_oe),
        .ram_rdata(b_ram_rdata)
    );

    // Behavioural RAM for the default-configured port.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata = f_en ? f_val :
                       ((ram_cs && ram_oe) ? mem[ram_addr] : 16'h0);
    assign b_ram_rdata = (b_ram_cs && b_ram_oe) ? 16'hA5C3 : 16'h0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue a request on the default port and trace n cycles after accept.
    task automatic run(input logic wr, input logic [5:0] addr,
                       input logic [15:0] data, input int n,
                       input int drop_at, input int sw_at,
                       input logic sw_wr, input int force_at,
                       input logic [15:0] force_v);
        logic       p_cs;
        logic [5:0] p_addr;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        tr_cs = '0; tr_we = '0; tr_oe = '0;
        tr_doe = '0; tr_rv = '0; tr_rdy = '0;
        for (int i = 0; i < 16; i++) tr_wd[i] = '0;
        rsp_d  = 16'hDEAD;
        p_cs   = 1'b0;
        p_addr = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (c == drop_at) req_valid = 1'b0;
            if (c == sw_at) req_write = sw_wr;
            if (c == force_at) begin
                f_en  = 1'b1;
                f_val = force_v;
            end
            tr_cs[c]  = ram_cs;
            tr_we[c]  = ram_we;
            tr_oe[c]  = ram_oe;
            tr_doe[c] = ram_data_oe;
            tr_rv[c]  = rsp_valid;
            tr_rdy[c] = req_ready;
            tr_wd[c]  = ram_wdata;
            if (rsp_valid) rsp_d = rsp_rdata;
            else if (rsp_rdata != 16'h0) stray++;
            if (ram_we && ram_oe) inv_bad++;
            if ((ram_we || ram_oe) && !ram_cs) inv_bad++;
            if (ram_cs && p_cs && ram_addr != p_addr) inv_bad++;
            if (ram_oe && ram_data_oe) inv_bad++;
            p_cs   = ram_cs;
            p_addr = ram_addr;
        end
        f_en = 1'b0;
    endtask

    initial begin
        logic [15:0] b_cs, b_oe, b_rv;
        logic [15:0] b_d;
        int          rv_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_zero", |{req_ready, rsp_valid, rsp_rdata, ram_addr,
                            ram_cs, ram_we, ram_oe, ram_wdata,
                            ram_data_oe}, 0);
        chk("reset_zero_b", |{b_req_ready, b_rsp_valid, b_ram_cs,
                              b_ram_oe, b_ram_we}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_rdy", req_ready, 1);
        chk("reset_rdy_b", b_req_ready, 1);

        // Short-phase port: SETUP 2, STROBE 1, no HOLD.
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 6'd3;
        b_cs = '0; b_oe = '0; b_rv = '0; b_d = 16'hDEAD;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) b_req_valid = 1'b0;
            b_cs[c] = b_ram_cs;
            b_oe[c] = b_ram_oe;
            b_rv[c] = b_rsp_valid;
            if (b_rsp_valid) b_d = b_rsp_rdata;
        end
        chk("t4_oe", b_oe, 16'h0008);
        chk("t4_cs", b_cs, 16'h000E);
        chk("t4_rv", b_rv, 16'h0010);
        chk("t4_rdata", b_d, 16'hA5C3);

        // Write 0x1234 to address 5.
        run(1'b1, 6'd5, 16'h1234, 6, 1, 0, 1'b0, 0, 16'h0);
        chk("t1_cs", tr_cs, 16'h001E);
        chk("t1_we", tr_we, 16'h000C);
        chk("t1_oe", tr_oe, 16'h0000);
        chk("t1_doe", tr_doe, 16'h001E);
        chk("t1_wd1", tr_wd[1], 16'h1234);
        chk("t1_wd4", tr_wd[4], 16'h1234);
        chk("t1_rv", tr_rv, 16'h0020);
        chk("t1_rsp", rsp_d, 16'h0000);
        chk("t1_rdy", tr_rdy, 16'h0040);
        chk("t1_mem", mem[5], 16'h1234);

        // Read it back.
        run(1'b0, 6'd5, 16'h0, 6, 1, 0, 1'b0, 0, 16'h0);
        chk("t2_oe", tr_oe, 16'h000C);
        chk("t2_we", tr_we, 16'h0000);
        chk("t2_doe", tr_doe, 16'h0000);
        chk("t2_rv", tr_rv, 16'h0020);
        chk("t2_rsp", rsp_d, 16'h1234);

        // Valid held across write 63/0xFFFF then read 63.
        run(1'b1, 6'd63, 16'hFFFF, 12, 7, 1, 1'b0, 0, 16'h0);
        chk("t3_rdy", tr_rdy, 16'h1040);
        chk("t3_rv", tr_rv, 16'h0820);
        chk("t3_cs", tr_cs, 16'h079E);
        chk("t3_we", tr_we, 16'h000C);
        chk("t3_oe", tr_oe, 16'h0300);
        chk("t3_rsp", rsp_d, 16'hFFFF);

        // Read data must be sampled at the end of STROBE, not during HOLD.
        run(1'b1, 6'd7, 16'h0BEE, 6, 1, 0, 1'b0, 0, 16'h0);
        run(1'b0, 6'd7, 16'h0, 6, 1, 0, 1'b0, 4, 16'hF00D);
        chk("t6_rsp", rsp_d, 16'h0BEE);
        chk("t6_rv", tr_rv, 16'h0020);

        chk("invariants", inv_bad, 0);
        chk("rdata_idle_zero", stray, 0);

        // Reset during the second STROBE cycle of a write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'd10;
        req_wdata = 16'hDEAD;
        rv_cnt    = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rv_cnt++;
            if (c == 1) req_valid = 1'b0;
            if (c == 3) begin
                chk("t5_we_pre", ram_we, 1);
                rst = 1'b1;
            end
            if (c == 4) begin
                chk("t5_zero", |{req_ready, rsp_valid, rsp_rdata,
                                 ram_addr, ram_cs, ram_we, ram_oe,
                                 ram_wdata, ram_data_oe}, 0);
                rst = 1'b0;
            end
            if (c == 5) chk("t5_rdy", req_ready, 1);
        end
        chk("t5_no_rsp", rv_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_master.md
Name: ram_port_master

Overview:
- Clocked initiator that drives one port of the asynchronous cs/we/oe dual-port RAM used by the RRAM controller.
- Converts single-beat valid/ready read/write requests from the controller datapath into timed chip-select, write-enable and output-enable strobe sequences.
- Setup, strobe and hold phases are each a programmable number of cycles.
- Returns read data on a one-cycle response strobe.

Parameters:
DATA_WIDTH, 16, RAM data word width
ADDR_WIDTH, 6, RAM address width
SETUP_CYC, 1, cycles cs/address are asserted before the strobe (legal range 1..15)
STROBE_CYC, 2, cycles we or oe is asserted (legal range 1..15)
HOLD_CYC, 1, cycles cs/address/wdata are held after the strobe (legal range 0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_WIDTH  read data; 0 for write completions
ram_addr  output  ADDR_WIDTH  RAM address
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable
ram_wdata  output  DATA_WIDTH  data driven toward the RAM data bus
ram_data_oe  output  1  enable for the top-level tri-state driver of ram_wdata
ram_rdata  input  DATA_WIDTH  data returned from the RAM data bus

Behaviour:
- Reset:
  - Reset is synchronous and active-high, on clk.
  - At reset, state = IDLE.
  - All outputs are 0: req_ready, rsp_valid, rsp_rdata, ram_addr, ram_cs, ram_we, ram_oe, ram_wdata, ram_data_oe.
  - req_ready rises on the first cycle after rst deasserts.
- Output registering: all ram_* outputs are driven directly from flops, so the asynchronous RAM never sees glitches.
- FSM states and transitions:
  - IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
  - HOLD is skipped (STROBE -> DONE) when HOLD_CYC = 0.
  - A 4-bit phase counter reloads on each phase entry. Each phase lasts exactly its parameter count of cycles.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write flag, address and wdata, then go to SETUP.
  - Requests are accepted only in IDLE; req_ready = 0 in every other state.
- SETUP:
  - ram_cs = 1, ram_addr = latched address, ram_we = 0, ram_oe = 0.
  - For writes, ram_wdata = latched data and ram_data_oe = 1.
- STROBE:
  - ram_cs stays high.
  - Write: ram_we = 1, ram_oe = 0.
  - Read: ram_oe = 1, ram_we = 0, ram_data_oe = 0.
  - For a read, ram_rdata is registered into rsp_rdata on the clock edge that ends the last STROBE cycle.
  - ram_rdata is ignored at all other times.
- HOLD:
  - ram_cs = 1, ram_we = 0, ram_oe = 0.
  - ram_addr is held; for writes, ram_wdata and ram_data_oe are held.
- DONE:
  - ram_cs, ram_we, ram_oe and ram_data_oe are all 0.
  - rsp_valid = 1 for exactly one cycle. There is no response backpressure.
  - rsp_rdata = captured read data for reads, 0 for writes.
  - rsp_rdata returns to 0 the cycle after DONE.
- Latency and throughput:
  - rsp_valid is asserted SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles after the accepting edge (5 with defaults).
  - The next accept happens no earlier than 1 cycle after DONE.
  - Throughput is one transaction per (SETUP_CYC + STROBE_CYC + HOLD_CYC + 2) cycles.
- Request stability: req_* inputs may change freely after acceptance; only the latched copies are used.
- Invariants:
  - ram_we and ram_oe are never both high.
  - Neither is ever high unless ram_cs is high.
  - ram_addr never changes while ram_cs is high.
  - ram_data_oe is never high during a read transaction.
- Address range: the full address range 0..2^ADDR_WIDTH-1 is legal; there is no wrap or bounds logic.
- Reset mid-transaction:
  - All strobes drop at the reset edge.
  - The in-flight transaction is abandoned with no rsp_valid pulse.
  - A partially strobed write may have corrupted the RAM; that is acceptable.

Test Plan:
1. Defaults; write addr 5, data 0x1234, accepted at edge 0 -> ram_cs high cycles 1-4; ram_we high cycles 2-3; ram_data_oe high cycles 1-4 with ram_wdata = 0x1234; rsp_valid at cycle 5 with rsp_rdata = 0.
2. Read addr 5 after test 1 against a RAM model -> ram_oe high cycles 2-3; ram_we never high; rsp_valid at cycle 5 with rsp_rdata = 0x1234.
3. req_valid held high across two requests (write 63/0xFFFF, then read 63) -> req_ready low cycles 1-5; second request accepted at edge 6; read returns 0xFFFF at cycle 11.
4. SETUP_CYC = 2, STROBE_CYC = 1, HOLD_CYC = 0; one read -> ram_oe high in cycle 3 only; ram_cs high cycles 1-3; rsp_valid at cycle 4.
5. rst asserted during a write's second STROBE cycle -> next cycle all outputs 0; no rsp_valid; req_ready = 1 on the first cycle after rst releases.
6. Read in which the RAM model changes ram_rdata during the HOLD cycle -> rsp_rdata equals the value present at the end of STROBE, not the later value.
